// File: rtl/lane_share_sched_pkg.sv
// Shared types and limits for the lane_share_sched round-robin lane scheduler.
package lane_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam int SETTLE_MIN  = 1;
    localparam int SETTLE_MAX  = 15;
    localparam int SETTLE_CNT_W = 4;
    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;

    // Index width for n requesters, never narrower than one bit.
    function automatic int id_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/lane_share_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import lane_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        winner = '0;
        any    = |req;
        // Scan from the farthest offset down so the nearest request wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) winner = ID_W'(idx);
        end
    end

endmodule

// File: rtl/lane_share_sched.sv
// Round-robin scheduler sharing one inverter lane among NUM_REQ requesters.
// Optional LANE_CHECK_EN builds a sticky lane_result == ~lane_drive self-check.
module lane_share_sched
    import lane_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int SETTLE  = 1,
    localparam int ID_W   = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         lane_drive,
    input  logic [DATA_W-1:0]         lane_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    output logic                      lane_err
);

    if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
        $error("lane_share_sched: SETTLE must be within 1..15");
    end
    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
        $error("lane_share_sched: NUM_REQ must be within 2..8");
    end

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]       drive_d, rsp_data_d;
    logic                    rsp_valid_d;
    logic [ID_W-1:0]         rsp_id_d;
    logic [SETTLE_CNT_W-1:0] settle_q, settle_d;
    logic [ID_W-1:0]         winner;
    logic                    any_req;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .winner (winner),
        .any    (any_req)
    );

    // ena=0 falls through with every next value equal to the current one.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        drive_d     = lane_drive;
        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_data_d  = rsp_data;
        settle_d    = settle_q;
        req_ready   = '0;
        if (ena && rst_n) begin
            unique case (state_q)
                IDLE: if (any_req) begin
                    req_ready[winner] = 1'b1;
                    drive_d  = req_data[int'(winner)*DATA_W +: DATA_W];
                    rsp_id_d = winner;
                    rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
                    settle_d = SETTLE_CNT_W'(SETTLE - 1);
                    state_d  = DRIVE;
                end
                DRIVE: begin
                    if (settle_q == '0) state_d = CAPTURE;
                    else                settle_d = settle_q - SETTLE_CNT_W'(1);
                end
                CAPTURE: begin
                    rsp_data_d  = lane_result;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lane_drive <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            settle_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lane_drive <= drive_d;
            rsp_valid  <= rsp_valid_d;
            rsp_id     <= rsp_id_d;
            rsp_data   <= rsp_data_d;
            settle_q   <= settle_d;
        end
    end

    assign busy = (state_q != IDLE);

`ifdef LANE_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else if (ena && state_q == CAPTURE && lane_result != ~lane_drive) err_q <= 1'b1;
    end
    assign lane_err = err_q;
`else
    assign lane_err = 1'b0;
`endif

endmodule

// File: tb/tb_lane_share_sched.sv
// Directed self-checking bench for lane_share_sched (NUM_REQ=4, DATA_W=4, SETTLE=1).
module tb_lane_share_sched;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  lane_drive;
    logic [3:0]  lane_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_data;
    logic        busy;
    logic        lane_err;
    logic        lane_bad;

    int vectors = 0;
    int errors  = 0;

`ifdef LANE_CHECK_EN
    localparam logic LANE_CHK = 1'b1;
`else
    localparam logic LANE_CHK = 1'b0;
`endif

    lane_share_sched #(.NUM_REQ(4), .DATA_W(4), .SETTLE(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .lane_drive  (lane_drive),
        .lane_result (lane_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .lane_err    (lane_err)
    );

    // Inverter lane model, with a stuck-at-zero override for the self-check test.
    assign lane_result = lane_bad ? 4'h0 : ~lane_drive;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in an IDLE cycle with rsp_ready=1; returns in the following IDLE cycle.
    task automatic run_txn(input int id, input logic [3:0] drive, input logic [3:0] data);
        int c;
        check("grant", req_ready, 32'(1 << id));
        tick();
        c = 1;
        check("ready_drop", req_ready, 0);
        check("drive", lane_drive, drive);
        check("busy", busy, 1);
        while (!rsp_valid && c < 12) begin
            tick();
            c++;
        end
        check("latency", c, 3);
        check("rsp_id", rsp_id, id);
        check("rsp_data", rsp_data, data);
        tick();
    endtask

    initial begin
        int c;
        rst_n = 1'b0; ena = 1'b1; req_valid = 4'hF; req_data = 16'h0;
        rsp_ready = 1'b1; lane_bad = 1'b0;
        tick();
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_lane_drive", lane_drive, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_lane_err", lane_err, 0);

        rst_n = 1'b1; req_valid = 4'h0;
        tick();

        // Lone requester 1 with data A: lane returns 5.
        req_valid = 4'b0010; req_data = 16'h00A0;
        #1;
        check("single_grant", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0000;
        check("single_drive", lane_drive, 4'hA);
        c = 1;
        while (!rsp_valid && c < 12) begin
            tick();
            c++;
        end
        check("single_latency", c, 3);
        check("single_id", rsp_id, 1);
        check("single_data", rsp_data, 4'h5);
        tick();
        check("single_done_valid", rsp_valid, 0);
        check("single_done_busy", busy, 0);
        check("drive_held", lane_drive, 4'hA);

        // All valid; pointer is 2 after granting requester 1.
        req_data = 16'hC963; req_valid = 4'hF;
        #1;
        run_txn(2, 4'h9, 4'h6);
        run_txn(3, 4'hC, 4'h3);
        run_txn(0, 4'h3, 4'hC);
        run_txn(1, 4'h6, 4'h9);
        run_txn(2, 4'h9, 4'h6);

        // Backpressure on requester 0 (pointer now 3, wraps to 0).
        req_valid = 4'b0001; rsp_ready = 1'b0;
        #1;
        check("bp_grant", req_ready, 4'b0001);
        tick();
        c = 1;
        while (!rsp_valid && c < 12) begin
            tick();
            c++;
        end
        check("bp_latency", c, 3);
        for (int i = 0; i < 6; i++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_id", rsp_id, 0);
            check("bp_data", rsp_data, 4'hC);
            check("bp_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release_valid", rsp_valid, 0);
        check("bp_next_grant", req_ready, 4'b0001);

        // Freeze for 4 cycles in DRIVE: completion slips from 3 to 7 cycles.
        tick();
        c = 1;
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("frz_busy", busy, 1);
            check("frz_drive", lane_drive, 4'h3);
            check("frz_valid", rsp_valid, 0);
            check("frz_ready", req_ready, 0);
            tick();
            c++;
        end
        ena = 1'b1;
        while (!rsp_valid && c < 20) begin
            tick();
            c++;
        end
        check("frz_latency", c, 7);
        check("frz_data", rsp_data, 4'hC);

        // ena=0 blocks the handshake even with rsp_ready high.
        ena = 1'b0;
        tick();
        check("frz_rsp_hold", rsp_valid, 1);
        check("frz_rsp_busy", busy, 1);

        // Reset during RESP drops the transaction.
        rst_n = 1'b0; ena = 1'b1;
        tick();
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_drive", lane_drive, 0);
        check("mid_rst_id", rsp_id, 0);

        // Pointer back at 0; bad lane on drive 3.
        rst_n = 1'b1; req_valid = 4'hF; lane_bad = 1'b1;
        #1;
        run_txn(0, 4'h3, 4'h0);
        check("lane_err_set", lane_err, LANE_CHK);
        lane_bad = 1'b0;
        run_txn(1, 4'h6, 4'h9);
        check("lane_err_sticky", lane_err, LANE_CHK);
        rst_n = 1'b0;
        tick();
        check("lane_err_clear", lane_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
